rename_map_unit: RTL and testbench
==================================

// Module: rename_map_unit
// PURPOSE
//  Parametrised register-rename stage sitting between the decode queue and issue/ROB.
//  Maps architectural source/dest regs to physical regs via a front RAT (FRAT).
//  Allocates dest regs from a bitmap free list and tracks committed state in a retirement RAT (RRAT).
//  On flush, restores FRAT from RRAT and rebuilds the free list in one cycle. Valid/ready handshake on both sides.
// PARAMETERS
//  ARCH_REGS  32  architectural register count (AW = $clog2(ARCH_REGS))
//  PHYS_REGS  64  physical register count, > ARCH_REGS (PW = $clog2(PHYS_REGS))
//  PAYLOAD_W  170 opaque per-instruction payload (instr, PC, controls) carried alongside
// PORTS
//  CLK            in   1   clock
//  RESET          in   1   synchronous, active-high reset
//  flush          in   1   squash in-flight state, restore committed map
//  in_valid       in   1   decoded instruction present
//  in_ready       out  1   stage accepts this cycle
//  in_src_a       in   AW  arch source A
//  in_src_b       in   AW  arch source B
//  in_dst         in   AW  arch destination
//  in_dst_wr      in   1   instruction writes in_dst
//  in_payload     in   PAYLOAD_W  passthrough
//  out_valid      out  1   renamed instruction present
//  out_ready      in   1   downstream accepts
//  out_psrc_a     out  PW  physical source A
//  out_psrc_b     out  PW  physical source B
//  out_pdst       out  PW  newly allocated physical dest (0 if no write)
//  out_old_pdst   out  PW  previous FRAT mapping of dest (for ROB bookkeeping)
//  out_dst_wr     out  1   effective dest write (in_dst_wr && in_dst != 0)
//  out_payload    out  PAYLOAD_W  passthrough
//  commit_valid   in   1   ROB retires a register-writing instruction
//  commit_areg    in   AW  retired arch dest
//  commit_preg    in   PW  retired phys dest
//  free_count     out  PW+1  number of free physical regs
// BEHAVIOUR
//  Reset: FRAT[i]=RRAT[i]=i; committed bitmap = regs 0..ARCH_REGS-1; free bitmap = ARCH_REGS..PHYS_REGS-1.
//   All out_* = 0; free_count = PHYS_REGS-ARCH_REGS.
//  in_ready = !flush && (!out_valid || out_ready) && (free_count != 0); independent of in_valid.
//  Accept (in_valid && in_ready): 1-cycle latency; output register loads.
//   psrc_* = FRAT[src] read before this cycle's update.
//   If dst write is effective: pdst = lowest-index free bit, clear it, FRAT[dst] <= pdst, old_pdst = prior FRAT[dst].
//  Arch reg 0 is never renamed: src 0 -> phys 0; dst 0 -> out_dst_wr=0, pdst=0, no allocation.
//  No accept and out_ready: out_valid <= 0. No accept and !out_ready: outputs hold.
//  Commit: RRAT[commit_areg] <= commit_preg.
//   Prior RRAT[commit_areg] cleared from committed bitmap and set in free bitmap.
//   commit_preg set in committed bitmap. commit_areg 0 is ignored.
//  Same-cycle alloc + commit: both apply; a freed reg is allocatable from the next cycle only.
//  free_count tracks: +1 on free, -1 on alloc, net 0 when both occur.
//  Flush (highest priority):
//   FRAT <= RRAT including any same-cycle commit; free <= ~committed_next (reg 0 never free).
//   out_valid <= 0; no accept that cycle; free_count recomputed as PHYS_REGS - ARCH_REGS.
//  Free list empty: in_ready=0 even for non-writing instructions (simple, conservative).
//  Reset during operation: same as power-up reset, overrides flush/commit.
// CONFIGURATION
//  RENAME_PERF_EN defined: adds out ports perf_renamed[31:0], perf_stall_free[31:0], perf_flushes[15:0].
//   perf_renamed: increments per accepted instruction.
//   perf_stall_free: increments on cycles with in_valid && free_count==0.
//   perf_flushes: increments per flush.
//   All counters saturate and clear on RESET (not on flush).
//  RENAME_PERF_EN undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  Reset, then rename r5<-r1,r2 (wr=1): psrc_a=1, psrc_b=2, pdst=32, old_pdst=5, free_count=31.
//  Back-to-back r5 writes then read r5: 2nd old_pdst=32, pdst=33; reader psrc_a=33.
//  Dest r0 with wr=1: out_dst_wr=0, pdst=0, free_count unchanged.
//  32 allocs with no commits: in_ready=0, perf_stall_free counts; one commit (r5,p32) frees p5, in_ready=1 next cycle.
//  Commit (r7,p40) + flush same cycle: FRAT[7]=40, p7 free, free_count=32, out_valid=0.
//  out_ready=0 for 3 cycles: outputs hold stable, in_ready=0, no FRAT change.

Source files
------------

// File: rtl/rename_map_unit.sv
// Register-rename stage: FRAT lookup, bitmap free-list allocation, RRAT commit, one-cycle flush recovery.
// Define RENAME_PERF_EN to add saturating perf counters (perf_renamed, perf_stall_free, perf_flushes).
module rename_map_unit #(
  parameter  int ARCH_REGS = 32,
  parameter  int PHYS_REGS = 64,
  parameter  int PAYLOAD_W = 170,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHYS_REGS)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_src_a,
  input  logic [AW-1:0]        in_src_b,
  input  logic [AW-1:0]        in_dst,
  input  logic                 in_dst_wr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_psrc_a,
  output logic [PW-1:0]        out_psrc_b,
  output logic [PW-1:0]        out_pdst,
  output logic [PW-1:0]        out_old_pdst,
  output logic                 out_dst_wr,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 commit_valid,
  input  logic [AW-1:0]        commit_areg,
  input  logic [PW-1:0]        commit_preg,
  output logic [PW:0]          free_count
`ifdef RENAME_PERF_EN
  ,
  output logic [31:0]          perf_renamed,
  output logic [31:0]          perf_stall_free,
  output logic [15:0]          perf_flushes
`endif
);

  localparam logic [PHYS_REGS-1:0] RESET_COMMITTED =
    {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
  localparam logic [PW:0] RESET_FREE_COUNT = (PW+1)'(PHYS_REGS - ARCH_REGS);

  logic [PW-1:0]        r_frat [ARCH_REGS];
  logic [PW-1:0]        r_rrat [ARCH_REGS];
  logic [PHYS_REGS-1:0] r_committed;
  logic [PHYS_REGS-1:0] r_free;
  logic [PW:0]          r_free_count;

  logic                 r_out_valid;
  logic [PW-1:0]        r_out_psrc_a;
  logic [PW-1:0]        r_out_psrc_b;
  logic [PW-1:0]        r_out_pdst;
  logic [PW-1:0]        r_out_old_pdst;
  logic                 r_out_dst_wr;
  logic [PAYLOAD_W-1:0] r_out_payload;

  logic                 w_accept;
  logic                 w_dst_eff;
  logic                 w_alloc;
  logic                 w_commit;
  logic [PW-1:0]        w_rrat_old;
  logic [PW-1:0]        w_alloc_idx;
  logic [PHYS_REGS-1:0] w_committed_next;
  logic [PHYS_REGS-1:0] w_free_next;
  logic [PHYS_REGS-1:0] w_free_flush;

  // Handshake: a transfer happens on a cycle where valid && ready; ready never depends on valid,
  // and the output register holds its contents while out_valid && !out_ready.
  assign in_ready   = !flush && (!r_out_valid || out_ready) && (r_free_count != '0);
  assign w_accept   = in_valid && in_ready;
  assign w_dst_eff  = in_dst_wr && (in_dst != '0);
  assign w_alloc    = w_accept && w_dst_eff;
  assign w_commit   = commit_valid && (commit_areg != '0);
  assign w_rrat_old = r_rrat[commit_areg];

  // Lowest-index free register wins: the descending scan leaves the smallest set index last.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (r_free[i]) w_alloc_idx = PW'(i);
    end
  end

  always_comb begin
    w_committed_next = r_committed;
    w_free_next      = r_free;
    if (w_alloc) w_free_next[w_alloc_idx] = 1'b0;
    if (w_commit) begin
      w_committed_next[w_rrat_old]  = 1'b0;
      w_committed_next[commit_preg] = 1'b1;
      w_free_next[w_rrat_old]       = 1'b1;
    end
    w_free_flush    = ~w_committed_next;
    w_free_flush[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_frat[i] <= PW'(i);
        r_rrat[i] <= PW'(i);
      end
      r_committed    <= RESET_COMMITTED;
      r_free         <= ~RESET_COMMITTED;
      r_free_count   <= RESET_FREE_COUNT;
      r_out_valid    <= 1'b0;
      r_out_psrc_a   <= '0;
      r_out_psrc_b   <= '0;
      r_out_pdst     <= '0;
      r_out_old_pdst <= '0;
      r_out_dst_wr   <= 1'b0;
      r_out_payload  <= '0;
    end else begin
      if (w_commit) r_rrat[commit_areg] <= commit_preg;
      r_committed <= w_committed_next;
      if (flush) begin
        // Restored map must already include the commit retiring this same cycle.
        for (int i = 0; i < ARCH_REGS; i++) r_frat[i] <= r_rrat[i];
        if (w_commit) r_frat[commit_areg] <= commit_preg;
        r_free       <= w_free_flush;
        r_free_count <= RESET_FREE_COUNT;
        r_out_valid  <= 1'b0;
      end else begin
        r_free       <= w_free_next;
        r_free_count <= r_free_count + {{PW{1'b0}}, w_commit} - {{PW{1'b0}}, w_alloc};
        if (w_accept) begin
          r_out_valid    <= 1'b1;
          r_out_psrc_a   <= (in_src_a == '0) ? '0 : r_frat[in_src_a];
          r_out_psrc_b   <= (in_src_b == '0) ? '0 : r_frat[in_src_b];
          r_out_pdst     <= w_dst_eff ? w_alloc_idx : '0;
          r_out_old_pdst <= w_dst_eff ? r_frat[in_dst] : '0;
          r_out_dst_wr   <= w_dst_eff;
          r_out_payload  <= in_payload;
          if (w_alloc) r_frat[in_dst] <= w_alloc_idx;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_psrc_a   = r_out_psrc_a;
  assign out_psrc_b   = r_out_psrc_b;
  assign out_pdst     = r_out_pdst;
  assign out_old_pdst = r_out_old_pdst;
  assign out_dst_wr   = r_out_dst_wr;
  assign out_payload  = r_out_payload;
  assign free_count   = r_free_count;

`ifdef RENAME_PERF_EN
  logic [31:0] r_perf_renamed;
  logic [31:0] r_perf_stall_free;
  logic [15:0] r_perf_flushes;

  // Counters saturate and survive flush; only RESET clears them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_perf_renamed    <= '0;
      r_perf_stall_free <= '0;
      r_perf_flushes    <= '0;
    end else begin
      if (w_accept && (r_perf_renamed != '1)) r_perf_renamed <= r_perf_renamed + 32'd1;
      if (in_valid && (r_free_count == '0) && (r_perf_stall_free != '1))
        r_perf_stall_free <= r_perf_stall_free + 32'd1;
      if (flush && (r_perf_flushes != '1)) r_perf_flushes <= r_perf_flushes + 16'd1;
    end
  end

  assign perf_renamed    = r_perf_renamed;
  assign perf_stall_free = r_perf_stall_free;
  assign perf_flushes    = r_perf_flushes;
`endif

endmodule

// File: tb/tb_rename_map_unit.sv
// Bench for rename_map_unit: directed scenarios then random traffic against an array/queue rename model.
module tb_rename_map_unit;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int PAYLOAD_W = 170;
  localparam int AW = 5;
  localparam int PW = 6;

  logic                 CLK;
  logic                 RESET;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        in_src_a;
  logic [AW-1:0]        in_src_b;
  logic [AW-1:0]        in_dst;
  logic                 in_dst_wr;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [PW-1:0]        out_psrc_a;
  logic [PW-1:0]        out_psrc_b;
  logic [PW-1:0]        out_pdst;
  logic [PW-1:0]        out_old_pdst;
  logic                 out_dst_wr;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 commit_valid;
  logic [AW-1:0]        commit_areg;
  logic [PW-1:0]        commit_preg;
  logic [PW:0]          free_count;
`ifdef RENAME_PERF_EN
  logic [31:0]          perf_renamed;
  logic [31:0]          perf_stall_free;
  logic [15:0]          perf_flushes;
`endif

  rename_map_unit #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .PAYLOAD_W(PAYLOAD_W)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst), .in_dst_wr(in_dst_wr),
    .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psrc_a(out_psrc_a), .out_psrc_b(out_psrc_b), .out_pdst(out_pdst),
    .out_old_pdst(out_old_pdst), .out_dst_wr(out_dst_wr), .out_payload(out_payload),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
    .free_count(free_count)
`ifdef RENAME_PERF_EN
    , .perf_renamed(perf_renamed), .perf_stall_free(perf_stall_free), .perf_flushes(perf_flushes)
`endif
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural maps as arrays, free/committed as bit sets, ROB as a queue.
  int m_frat [ARCH_REGS];
  int m_rrat [ARCH_REGS];
  bit m_free [PHYS_REGS];
  bit m_comm [PHYS_REGS];
  bit m_ov;
  int m_psa, m_psb, m_pdst, m_old;
  bit m_dwr;
  logic [PAYLOAD_W-1:0] m_pay;
  int m_ren, m_stall, m_fl;
  typedef struct { int areg; int preg; } rob_t;
  rob_t rob_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_fc();
    int c = 0;
    for (int i = 0; i < PHYS_REGS; i++) if (m_free[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) begin m_frat[i] = i; m_rrat[i] = i; end
    for (int i = 0; i < PHYS_REGS; i++) begin m_comm[i] = (i < ARCH_REGS); m_free[i] = (i >= ARCH_REGS); end
    m_ov = 0; m_psa = 0; m_psb = 0; m_pdst = 0; m_old = 0; m_dwr = 0; m_pay = '0;
    m_ren = 0; m_stall = 0; m_fl = 0;
    rob_q.delete();
  endtask

  task automatic model_step(input bit rdy);
    bit acc, cv, dwr;
    int lf, oc, fc;
    fc  = m_fc();
    acc = in_valid && rdy;
    cv  = commit_valid && (commit_areg != 0);
    dwr = in_dst_wr && (in_dst != 0);
    if (in_valid && fc == 0) m_stall++;
    if (flush) m_fl++;
    if (acc) begin
      m_ren++;
      lf = -1;
      for (int i = 0; i < PHYS_REGS; i++) if (m_free[i] && lf < 0) lf = i;
      m_psa  = (in_src_a == 0) ? 0 : m_frat[in_src_a];
      m_psb  = (in_src_b == 0) ? 0 : m_frat[in_src_b];
      m_dwr  = dwr;
      m_pdst = dwr ? lf : 0;
      m_old  = dwr ? m_frat[in_dst] : 0;
      m_pay  = in_payload;
      m_ov   = 1;
      if (dwr) begin
        m_free[lf] = 0;
        m_frat[in_dst] = lf;
        rob_q.push_back('{areg: int'(in_dst), preg: lf});
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (cv) begin
      oc = m_rrat[commit_areg];
      m_comm[oc] = 0;
      m_free[oc] = 1;
      m_comm[commit_preg] = 1;
      m_rrat[commit_areg] = commit_preg;
    end
    if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) m_frat[i] = m_rrat[i];
      for (int i = 0; i < PHYS_REGS; i++) m_free[i] = !m_comm[i] && (i != 0);
      m_ov = 0;
      rob_q.delete();
    end
  endtask

  // Driver tasks
  task automatic idle();
    flush = 0; in_valid = 0; in_src_a = '0; in_src_b = '0; in_dst = '0; in_dst_wr = 0;
    in_payload = '0; out_ready = 1; commit_valid = 0; commit_areg = '0; commit_preg = '0;
  endtask

  task automatic set_in(input bit v, input int sa, input int sb, input int d, input bit wr);
    logic [191:0] t;
    for (int k = 0; k < 6; k++) t[k*32 +: 32] = $urandom;
    in_valid = v; in_src_a = AW'(sa); in_src_b = AW'(sb); in_dst = AW'(d); in_dst_wr = wr;
    in_payload = t[PAYLOAD_W-1:0];
  endtask

  task automatic do_reset();
    idle();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    model_reset();
  endtask

  // One clock: check in_ready before the edge, step the model, check outputs after it.
  task automatic cycle(input string tag);
    bit rdy;
    #1;
    rdy = !flush && (!m_ov || out_ready) && (m_fc() != 0);
    chk({tag, ".in_ready"}, in_ready, rdy);
    model_step(rdy);
    @(posedge CLK);
    #1;
    chk({tag, ".out_valid"}, out_valid, m_ov);
    if (m_ov) begin
      chk({tag, ".psrc_a"}, out_psrc_a, m_psa);
      chk({tag, ".psrc_b"}, out_psrc_b, m_psb);
      chk({tag, ".pdst"}, out_pdst, m_pdst);
      chk({tag, ".old_pdst"}, out_old_pdst, m_old);
      chk({tag, ".dst_wr"}, out_dst_wr, m_dwr);
      chk({tag, ".payload"}, out_payload, m_pay);
    end
    chk({tag, ".free_count"}, free_count, m_fc());
  endtask

  initial begin
    RESET = 1;
    idle();
    do_reset();

    // Reset state
    chk("reset.out_valid", out_valid, 0);
    chk("reset.outs", {out_psrc_a, out_psrc_b, out_pdst, out_old_pdst, out_dst_wr}, 0);
    chk("reset.payload", out_payload, 0);
    chk("reset.free_count", free_count, 32);
    chk("reset.in_ready", in_ready, 1);

    // r5 <- r1, r2
    set_in(1, 1, 2, 5, 1); cycle("ren1");
    chk("ren1.const", {out_psrc_a, out_psrc_b, out_pdst, out_old_pdst}, {6'd1, 6'd2, 6'd32, 6'd5});
    chk("ren1.fc_const", free_count, 31);

    // Back-to-back r5 writes, then a reader of r5
    set_in(1, 3, 4, 5, 1); cycle("ren2");
    chk("ren2.const", {out_pdst, out_old_pdst}, {6'd33, 6'd32});
    set_in(1, 5, 0, 9, 0); cycle("rd5");
    chk("rd5.const", {out_psrc_a, out_psrc_b, out_dst_wr}, {6'd33, 6'd0, 1'b0});

    // Destination r0 is never renamed
    set_in(1, 6, 7, 0, 1); cycle("dst0");
    chk("dst0.const", {out_dst_wr, out_pdst, free_count}, {1'b0, 6'd0, 7'd30});

    // Exhaust the free list
    for (int i = 0; i < 30; i++) begin
      set_in(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 1);
      cycle("fill");
    end
    set_in(1, 1, 1, 3, 1); cycle("empty");
    chk("empty.fc_const", free_count, 0);
    chk("empty.in_ready_const", in_ready, 0);
    cycle("empty2");
`ifdef RENAME_PERF_EN
    chk("empty.perf_stall", perf_stall_free, m_stall);
`endif
    // Retiring (r5,p32) frees p5, allocatable from the next cycle
    set_in(0, 0, 0, 0, 0);
    commit_valid = 1; commit_areg = 5; commit_preg = 32;
    cycle("commit5");
    commit_valid = 0;
    chk("commit5.in_ready_const", in_ready, 1);
    set_in(1, 0, 0, 3, 1); cycle("realloc");
    chk("realloc.pdst_const", out_pdst, 5);

    // Commit (r7,p40) together with flush
    do_reset();
    set_in(1, 1, 2, 3, 1); cycle("pre_flush");
    set_in(1, 1, 2, 4, 1);
    flush = 1; commit_valid = 1; commit_areg = 7; commit_preg = 40;
    cycle("flush");
    flush = 0; commit_valid = 0;
    chk("flush.const", {out_valid, free_count}, {1'b0, 7'd32});
    set_in(1, 7, 3, 2, 1); cycle("post_flush");
    chk("post_flush.const", {out_psrc_a, out_psrc_b, out_pdst}, {6'd40, 6'd3, 6'd7});

    // Downstream back-pressure holds the output register
    set_in(1, 2, 7, 11, 1); cycle("hold_load");
    out_ready = 0;
    set_in(1, 11, 11, 11, 1);
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      chk("hold.in_ready_const", in_ready, 0);
    end
    out_ready = 1;
    set_in(0, 0, 0, 0, 0); cycle("hold_drain");
    set_in(1, 11, 2, 0, 0); cycle("hold_read");

    // Random traffic with in-order commits from the model ROB
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rob_t h;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 40) == 0);
      commit_valid = 0;
      commit_areg = AW'($urandom_range(0, 31));
      commit_preg = PW'($urandom_range(0, 63));
      if (rob_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        h = rob_q.pop_front();
        commit_valid = 1; commit_areg = AW'(h.areg); commit_preg = PW'(h.preg);
      end else if ($urandom_range(0, 15) == 0) begin
        commit_valid = 1; commit_areg = '0;
      end
      cycle("rand");
    end
    idle();
`ifdef RENAME_PERF_EN
    chk("perf.renamed", perf_renamed, m_ren);
    chk("perf.stall", perf_stall_free, m_stall);
    chk("perf.flushes", perf_flushes, m_fl);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
